// File: rtl/cfg_serial_sequencer.sv
// Loads the VREF/DATA/CONVER/COMP serial configuration registers: one clear pulse,
// then each field streamed marker-first, LSB-first, on its own serial line.
module cfg_serial_sequencer #(
    parameter int W_VREF = 4,
    parameter int W_DATA = 8,
    parameter int W_CONV = 8,
    parameter int W_COMP = 6,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [W_VREF-1:0] vref_val,
    input  logic [W_DATA-1:0] data_val,
    input  logic [W_CONV-1:0] conv_val,
    input  logic [W_COMP-1:0] comp_val,
    output logic              sr_clr,
    output logic              s_vref,
    output logic              s_data,
    output logic              s_conv,
    output logic              s_comp,
    output logic [1:0]        field,
    output logic              busy,
    output logic              done
);

    localparam int MAXW_A = (W_VREF > W_DATA) ? W_VREF : W_DATA;
    localparam int MAXW_B = (W_CONV > W_COMP) ? W_CONV : W_COMP;
    localparam int MAXW   = (MAXW_A > MAXW_B) ? MAXW_A : MAXW_B;
    localparam int BW     = $clog2(MAXW + 1);
    localparam int GW     = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_r;
    logic [BW-1:0]    bit_cnt_r;
    logic [GW-1:0]    gap_cnt_r;
    logic [MAXW-1:0]  vref_r;
    logic [MAXW-1:0]  data_r;
    logic [MAXW-1:0]  conv_r;
    logic [MAXW-1:0]  comp_r;

    function automatic logic [BW-1:0] field_width(input logic [1:0] f);
        case (f)
            2'd0:    field_width = BW'(W_VREF);
            2'd1:    field_width = BW'(W_DATA);
            2'd2:    field_width = BW'(W_CONV);
            default: field_width = BW'(W_COMP);
        endcase
    endfunction

    // One-hot lane pattern {comp, conv, data, vref} for bit index k of field f;
    // k = 0 is the marker, k >= 1 carries word bit k-1.
    function automatic logic [3:0] lane_bits(input logic [1:0] f, input logic [BW-1:0] k);
        logic [MAXW-1:0] word;
        logic [MAXW-1:0] sh;
        logic            b;
        case (f)
            2'd0:    word = vref_r;
            2'd1:    word = data_r;
            2'd2:    word = conv_r;
            default: word = comp_r;
        endcase
        sh = word >> (k - BW'(1));
        if (k == '0) begin
            b = 1'b1;
        end else begin
            b = sh[0];
        end
        lane_bits = {3'b000, b} << f;
    endfunction

    // Sequencer state, counters, holding words and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            bit_cnt_r <= '0;
            gap_cnt_r <= '0;
            vref_r    <= '0;
            data_r    <= '0;
            conv_r    <= '0;
            comp_r    <= '0;
            sr_clr    <= 1'b0;
            {s_comp, s_conv, s_data, s_vref} <= 4'b0000;
            field     <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort && (state_r != S_IDLE)) begin
            // Holding words are kept; the next load starts with a clear anyway.
            state_r   <= S_IDLE;
            bit_cnt_r <= '0;
            gap_cnt_r <= '0;
            sr_clr    <= 1'b0;
            {s_comp, s_conv, s_data, s_vref} <= 4'b0000;
            field     <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    {s_comp, s_conv, s_data, s_vref} <= 4'b0000;
                    if (start && !abort) begin
                        vref_r  <= MAXW'(vref_val);
                        data_r  <= MAXW'(data_val);
                        conv_r  <= MAXW'(conv_val);
                        comp_r  <= MAXW'(comp_val);
                        state_r <= S_CLEAR;
                        sr_clr  <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        sr_clr  <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_r   <= S_SHIFT;
                    sr_clr    <= 1'b0;
                    field     <= 2'd0;
                    bit_cnt_r <= '0;
                    {s_comp, s_conv, s_data, s_vref} <= lane_bits(2'd0, '0);
                end
                S_SHIFT: begin
                    if (bit_cnt_r != field_width(field)) begin
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                        {s_comp, s_conv, s_data, s_vref} <= lane_bits(field, bit_cnt_r + BW'(1));
                    end else if (field == 2'd3) begin
                        state_r   <= S_DONE;
                        bit_cnt_r <= '0;
                        done      <= 1'b1;
                        {s_comp, s_conv, s_data, s_vref} <= 4'b0000;
                    end else if (GAP > 0) begin
                        state_r   <= S_GAP;
                        bit_cnt_r <= '0;
                        gap_cnt_r <= GW'(1);
                        {s_comp, s_conv, s_data, s_vref} <= 4'b0000;
                    end else begin
                        field     <= field + 2'd1;
                        bit_cnt_r <= '0;
                        {s_comp, s_conv, s_data, s_vref} <= lane_bits(field + 2'd1, '0);
                    end
                end
                S_GAP: begin
                    if (gap_cnt_r == GW'(GAP)) begin
                        state_r   <= S_SHIFT;
                        gap_cnt_r <= '0;
                        field     <= field + 2'd1;
                        {s_comp, s_conv, s_data, s_vref} <= lane_bits(field + 2'd1, '0);
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                        {s_comp, s_conv, s_data, s_vref} <= 4'b0000;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    field   <= 2'd0;
                    {s_comp, s_conv, s_data, s_vref} <= 4'b0000;
                end
                default: begin
                    state_r   <= S_IDLE;
                    bit_cnt_r <= '0;
                    gap_cnt_r <= '0;
                    sr_clr    <= 1'b0;
                    {s_comp, s_conv, s_data, s_vref} <= 4'b0000;
                    field     <= 2'd0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_serial_sequencer.sv
// Directed bench for cfg_serial_sequencer: default-GAP and GAP=0 instances,
// cycle-exact timing model, hand-computed bit patterns and model receiving registers.
module tb_cfg_serial_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [3:0] vref_val;
    logic [7:0] data_val, conv_val;
    logic [5:0] comp_val;

    logic       sr_clr_a, s_vref_a, s_data_a, s_conv_a, s_comp_a, busy_a, done_a;
    logic [1:0] field_a;
    logic       sr_clr_z, s_vref_z, s_data_z, s_conv_z, s_comp_z, busy_z, done_z;
    logic [1:0] field_z;

    logic [8:0] pack_a, pack_z;
    assign pack_a = {sr_clr_a, s_vref_a, s_data_a, s_conv_a, s_comp_a, field_a, busy_a, done_a};
    assign pack_z = {sr_clr_z, s_vref_z, s_data_z, s_conv_z, s_comp_z, field_z, busy_z, done_z};

    cfg_serial_sequencer dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vref_val(vref_val), .data_val(data_val), .conv_val(conv_val), .comp_val(comp_val),
        .sr_clr(sr_clr_a), .s_vref(s_vref_a), .s_data(s_data_a), .s_conv(s_conv_a),
        .s_comp(s_comp_a), .field(field_a), .busy(busy_a), .done(done_a)
    );

    cfg_serial_sequencer #(.GAP(0)) dut_z (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vref_val(vref_val), .data_val(data_val), .conv_val(conv_val), .comp_val(comp_val),
        .sr_clr(sr_clr_z), .s_vref(s_vref_z), .s_data(s_data_z), .s_conv(s_conv_z),
        .s_comp(s_comp_z), .field(field_z), .busy(busy_z), .done(done_z)
    );

    always #5 clk = ~clk;

    // Model receiving registers: bit 0 is the stop bit, frozen once the marker lands there.
    logic [4:0] rx_v = '0;
    logic [8:0] rx_d = '0;
    logic [8:0] rx_c = '0;
    logic [6:0] rx_p = '0;
    always @(posedge clk) begin
        if (sr_clr_a) begin
            rx_v <= '0; rx_d <= '0; rx_c <= '0; rx_p <= '0;
        end else begin
            if (!rx_v[0]) rx_v <= {s_vref_a, rx_v[4:1]};
            if (!rx_d[0]) rx_d <= {s_data_a, rx_d[8:1]};
            if (!rx_c[0]) rx_c <= {s_conv_a, rx_c[8:1]};
            if (!rx_p[0]) rx_p <= {s_comp_a, rx_p[6:1]};
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_a_cnt, done_a_cyc, busy_a_cnt, clr_a_cnt, done_z_cnt, done_z_cyc;
    logic hist_clr[64];
    logic hist_v[64];
    logic hist_d[64];
    logic hist_p[64];

    typedef struct {
        logic [3:0] v;
        logic [7:0] d;
        logic [7:0] cv;
        logic [5:0] cp;
        int         exp_done;
        int         exp_done_z;
        int         exp_busy;
    } vec_t;

    // Expected outputs in cycle c (start sampled at edge 0), packed like pack_a.
    function automatic logic [8:0] model(input int c, input logic [3:0] v, input logic [7:0] d,
                                         input logic [7:0] cv, input logic [5:0] cp, input int gap);
        int         w[4];
        logic [7:0] val[4];
        int         p;
        bit         found;
        logic [3:0] ln;
        logic [1:0] fld;
        logic       b, dn, cl;
        w = '{4, 8, 8, 6};
        val[0] = {4'b0000, v}; val[1] = d; val[2] = cv; val[3] = {2'b00, cp};
        ln = 4'b0000; fld = 2'd0; b = 1'b0; dn = 1'b0; cl = 1'b0; found = 1'b0; p = 0;
        if (c == 1) begin
            cl = 1'b1; b = 1'b1;
        end else if (c >= 2) begin
            p = c - 2;
            for (int f = 0; f < 4; f++) begin
                if (!found) begin
                    if (p < w[f] + 1) begin
                        found = 1'b1; b = 1'b1; fld = f[1:0];
                        ln[f] = (p == 0) ? 1'b1 : val[f][p-1];
                    end else begin
                        p = p - (w[f] + 1);
                        if (f < 3) begin
                            if (p < gap) begin
                                found = 1'b1; b = 1'b1; fld = f[1:0];
                            end else begin
                                p = p - gap;
                            end
                        end
                    end
                end
            end
            if (!found && p == 0) begin
                b = 1'b1; dn = 1'b1; fld = 2'd3;
            end
        end
        return {cl, ln[0], ln[1], ln[2], ln[3], fld, b, dn};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rx(input logic [3:0] v, input logic [7:0] d, input logic [7:0] cv, input logic [5:0] cp);
        chk_int("rx_vref_val", int'(rx_v[4:1]), int'(v));
        chk_int("rx_vref_stop", int'(rx_v[0]), 1);
        chk_int("rx_data_val", int'(rx_d[8:1]), int'(d));
        chk_int("rx_data_stop", int'(rx_d[0]), 1);
        chk_int("rx_conv_val", int'(rx_c[8:1]), int'(cv));
        chk_int("rx_conv_stop", int'(rx_c[0]), 1);
        chk_int("rx_comp_val", int'(rx_p[6:1]), int'(cp));
        chk_int("rx_comp_stop", int'(rx_p[0]), 1);
    endtask

    // One load started at edge 0, checked cycle by cycle through cycle ncyc.
    // restart/abort/reset events are applied during the given cycle (<=0 disables).
    task automatic run_load(input logic [3:0] v, input logic [7:0] d, input logic [7:0] cv,
                            input logic [5:0] cp, input int ncyc, input int restart_c,
                            input int abort_c, input int rst_c, input bit check_z);
        logic [8:0] exp;
        done_a_cnt = 0; done_a_cyc = -1; busy_a_cnt = 0; clr_a_cnt = 0;
        done_z_cnt = 0; done_z_cyc = -1;
        cyc = 0;
        vref_val = v; data_val = d; conv_val = cv; comp_val = cp;
        start = 1'b1;
        step();
        start = 1'b0;
        vref_val = ~v; data_val = ~d; conv_val = ~cv; comp_val = ~cp;
        while (cyc <= ncyc) begin
            exp = model(cyc, v, d, cv, cp, 2);
            if (abort_c > 0 && cyc > abort_c) exp = '0;
            if (rst_c > 0 && cyc > rst_c) exp = '0;
            chk("seq_gap2", pack_a, exp);
            if (check_z) chk("seq_gap0", pack_z, model(cyc, v, d, cv, cp, 0));
            hist_clr[cyc] = sr_clr_a; hist_v[cyc] = s_vref_a;
            hist_d[cyc] = s_data_a; hist_p[cyc] = s_comp_a;
            if (busy_a) busy_a_cnt++;
            if (sr_clr_a) clr_a_cnt++;
            if (done_a) begin done_a_cnt++; if (done_a_cyc < 0) done_a_cyc = cyc; end
            if (done_z) begin done_z_cnt++; if (done_z_cyc < 0) done_z_cyc = cyc; end
            if (cyc == restart_c) begin
                start = 1'b1;
                vref_val = 4'h3; data_val = 8'h81; conv_val = 8'h00; comp_val = 6'h15;
            end
            if (cyc == abort_c) abort = 1'b1;
            if (cyc == rst_c) rst = 1'b1;
            step();
            start = 1'b0; abort = 1'b0; rst = 1'b0;
        end
    endtask

    vec_t vecs[3];
    bit   pat_v[5];
    bit   pat_d[9];
    bit   pat_p[7];

    initial begin
        vecs[0] = '{v: 4'hA, d: 8'h5C, cv: 8'hFF, cp: 6'h2B, exp_done: 38, exp_done_z: 32, exp_busy: 38};
        vecs[1] = '{v: 4'h0, d: 8'h00, cv: 8'h00, cp: 6'h00, exp_done: 38, exp_done_z: 32, exp_busy: 38};
        vecs[2] = '{v: 4'hF, d: 8'hA5, cv: 8'h3C, cp: 6'h3F, exp_done: 38, exp_done_z: 32, exp_busy: 38};
        pat_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        pat_d = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        pat_p = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        vref_val = '0; data_val = '0; conv_val = '0; comp_val = '0;
        step(); step();
        chk("reset_a", pack_a, 9'd0);
        chk("reset_z", pack_z, 9'd0);
        rst = 1'b0;
        step();

        // Table-driven full loads on both builds.
        for (int i = 0; i < 3; i++) begin
            run_load(vecs[i].v, vecs[i].d, vecs[i].cv, vecs[i].cp, 45, -1, -1, -1, 1'b1);
            chk_int("done_cycle", done_a_cyc, vecs[i].exp_done);
            chk_int("done_count", done_a_cnt, 1);
            chk_int("busy_cycles", busy_a_cnt, vecs[i].exp_busy);
            chk_int("clr_count", clr_a_cnt, 1);
            chk_int("done_cycle_gap0", done_z_cyc, vecs[i].exp_done_z);
            chk_int("done_count_gap0", done_z_cnt, 1);
            chk_rx(vecs[i].v, vecs[i].d, vecs[i].cv, vecs[i].cp);
            if (i == 0) begin
                chk_int("clr_in_cycle1", int'(hist_clr[1]), 1);
                for (int k = 0; k < 5; k++) chk_int("s_vref_pattern", int'(hist_v[2+k]), int'(pat_v[k]));
                for (int k = 0; k < 9; k++) chk_int("s_data_pattern", int'(hist_d[9+k]), int'(pat_d[k]));
                for (int k = 0; k < 7; k++) chk_int("s_comp_pattern", int'(hist_p[31+k]), int'(pat_p[k]));
            end
        end

        // Random words through the model receiving registers.
        for (int i = 0; i < 3; i++) begin
            logic [3:0] rv; logic [7:0] rd, rc; logic [5:0] rp;
            rv = 4'($urandom); rd = 8'($urandom); rc = 8'($urandom); rp = 6'($urandom);
            run_load(rv, rd, rc, rp, 42, -1, -1, -1, 1'b1);
            chk_rx(rv, rd, rc, rp);
        end

        // start re-pulsed in cycle 10 with other words: ignored.
        run_load(4'h6, 8'hC3, 8'h5A, 6'h09, 50, 10, -1, -1, 1'b1);
        chk_int("restart_done_count", done_a_cnt, 1);
        chk_int("restart_done_cycle", done_a_cyc, 38);
        chk_int("restart_clr_count", clr_a_cnt, 1);
        chk_rx(4'h6, 8'hC3, 8'h5A, 6'h09);

        // Abort mid-DATA, then a fresh full load.
        run_load(4'h9, 8'h77, 8'h12, 6'h30, 45, -1, 15, -1, 1'b0);
        chk_int("abort_no_done", done_a_cnt, 0);
        run_load(4'h2, 8'hE1, 8'h4D, 6'h1E, 42, -1, -1, -1, 1'b1);
        chk_int("after_abort_clr", int'(hist_clr[1]), 1);
        chk_int("after_abort_done", done_a_cyc, 38);
        chk_rx(4'h2, 8'hE1, 8'h4D, 6'h1E);

        // Reset in cycle 25, then start+abort together in IDLE.
        run_load(4'h5, 8'h99, 8'hF0, 6'h2A, 40, -1, -1, 25, 1'b0);
        chk_int("rst_no_done", done_a_cnt, 0);
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("start_abort_idle_a", pack_a, 9'd0);
            chk("start_abort_idle_z", pack_z, 9'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
